// File: rtl/mem_pkg.sv
// Shared types and bus widths for the instruction/data memory arbiter.
package mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arb_state_e;

  typedef enum logic {PORT_I, PORT_D} port_sel_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the instruction port, data port and memory bus seen by the arbiter.
interface mem_arbiter_if;
  import mem_pkg::*;

  logic              i_valid;
  logic              i_ready;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;

  logic              d_valid;
  logic              d_ready;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic [DATA_W-1:0] d_rdata;

  logic              err;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport master (
    input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, err,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  // Requesters and memory side.
  modport slave (
    output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, err,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a conflict goes to the port
// that did not hold the previous grant.
module rr_pick2
  import mem_pkg::*;
(
  input  logic      i_valid,
  input  logic      d_valid,
  input  port_sel_e last_gnt,
  output logic      any_req,
  output port_sel_e pick
);

  always_comb begin
    any_req = i_valid | d_valid;
    pick    = PORT_D;
    if (i_valid && d_valid) begin
      pick = (last_gnt == PORT_D) ? PORT_I : PORT_D;
    end else if (i_valid) begin
      pick = PORT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus between the I-cache refill port and the data port,
// one registered grant per transaction, with a per-transaction watchdog.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);

  arb_state_e           state_q, state_d;
  port_sel_e            last_gnt_q, last_gnt_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic                 mem_valid_q, mem_valid_d;
  logic                 any_req, granted, sel_i, sel_d, timeout, done;
  port_sel_e            pick;

  rr_pick2 u_pick (
    .i_valid  (bus.i_valid),
    .d_valid  (bus.d_valid),
    .last_gnt (last_gnt_q),
    .any_req  (any_req),
    .pick     (pick)
  );

  assign granted = (state_q != IDLE);
  assign sel_i   = (state_q == GNT_I);
  assign sel_d   = (state_q == GNT_D);
  assign wd_inc  = wd_q + 1'b1;
  // An acknowledge in the timeout cycle still counts as a normal completion.
  assign timeout = granted && !bus.mem_ready && (&wd_inc);
  assign done    = granted && (bus.mem_ready || timeout);

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    wd_d        = wd_q;
    mem_valid_d = mem_valid_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = (pick == PORT_I) ? GNT_I : GNT_D;
          last_gnt_d  = pick;
          wd_d        = '0;
          mem_valid_d = 1'b1;
        end
      end
      GNT_I, GNT_D: begin
        if (done) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
        end else begin
          wd_d = wd_inc;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_gnt_q  <= PORT_D;
      wd_q        <= '0;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      wd_q        <= wd_d;
      mem_valid_q <= mem_valid_d;
    end
  end

  // Outside an I grant the bus carries the data port's fields.
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = sel_i ? bus.i_addr : bus.d_addr;
  assign bus.mem_wdata = sel_i ? '0 : bus.d_wdata;
  assign bus.mem_wstrb = sel_i ? '0 : bus.d_wstrb;

  assign bus.i_ready = sel_i && done;
  assign bus.d_ready = sel_d && done;
  assign bus.i_rdata = (sel_i && bus.mem_ready) ? bus.mem_rdata : '0;
  assign bus.d_rdata = (sel_d && bus.mem_ready) ? bus.mem_rdata : '0;
  assign bus.err     = timeout;

endmodule
